// File: rtl/nonce_hash_engine.sv
// nonce_hash_engine: serial double SHA-256 over a nonce sweep.
// For each nonce it runs the second-block compression from a latched
// midstate and then hashes the resulting 256-bit digest again. Word H0 of
// each final digest lands in its own slot of the answers vector.
module nonce_hash_engine #(
  parameter int unsigned NUM_NONCES = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [255:0]              midstate,
  input  logic [95:0]               tail,
  output logic                      busy,
  output logic                      done,
  output logic [32*NUM_NONCES-1:0]  answers
);

  localparam int unsigned NW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
  localparam logic [NW-1:0] LAST_NONCE = NW'(NUM_NONCES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP1 = 3'd1;
  localparam logic [2:0] S_RND1   = 3'd2;
  localparam logic [2:0] S_FIN1   = 3'd3;
  localparam logic [2:0] S_RND2   = 3'd4;
  localparam logic [2:0] S_FIN2   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    ssig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    ssig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  logic [2:0]     state;
  logic [255:0]   mid_q;
  logic [95:0]    tail_q;
  logic [NW-1:0]  nonce_q;
  logic [5:0]     round_q;
  logic [31:0]    a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [31:0]    w_q [16];

  logic [31:0]    big_s0, big_s1, ch_v, maj_v, t1, t2, w_new;
  logic [31:0]    mid_w [8];
  logic [31:0]    work_w [8];
  logic [31:0]    d1_w [8];

  // One SHA-256 round plus the next schedule word, from the current registers.
  always_comb begin
    big_s1 = rotr(e_q, 6) ^ rotr(e_q, 11) ^ rotr(e_q, 25);
    ch_v   = (e_q & f_q) ^ (~e_q & g_q);
    t1     = h_q + big_s1 + ch_v + K_TAB[round_q] + w_q[0];
    big_s0 = rotr(a_q, 2) ^ rotr(a_q, 13) ^ rotr(a_q, 22);
    maj_v  = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
    t2     = big_s0 + maj_v;
    w_new  = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
  end

  // First-block digest: latched midstate plus the finished working variables.
  always_comb begin
    work_w = '{a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
    for (int unsigned i = 0; i < 8; i++) begin
      mid_w[i] = mid_q[255 - 32*i -: 32];
      d1_w[i]  = mid_w[i] + work_w[i];
    end
  end

  // Sequencer: handshake, input capture, nonce and round counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      mid_q   <= '0;
      tail_q  <= '0;
      nonce_q <= '0;
      round_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mid_q   <= midstate;
            tail_q  <= tail;
            nonce_q <= '0;
            busy    <= 1'b1;
            state   <= S_SETUP1;
          end
        end
        S_SETUP1: begin
          round_q <= '0;
          state   <= S_RND1;
        end
        S_RND1: begin
          round_q <= round_q + 6'd1;
          if (round_q == 6'd63) state <= S_FIN1;
        end
        S_FIN1: begin
          round_q <= '0;
          state   <= S_RND2;
        end
        S_RND2: begin
          round_q <= round_q + 6'd1;
          if (round_q == 6'd63) state <= S_FIN2;
        end
        S_FIN2: begin
          if (nonce_q == LAST_NONCE) begin
            state <= S_DONE;
          end else begin
            nonce_q <= nonce_q + 1'b1;
            state   <= S_SETUP1;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Working variables a..h: load per block, then advance one round per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
    end else begin
      case (state)
        S_SETUP1: begin
          a_q <= mid_w[0]; b_q <= mid_w[1]; c_q <= mid_w[2]; d_q <= mid_w[3];
          e_q <= mid_w[4]; f_q <= mid_w[5]; g_q <= mid_w[6]; h_q <= mid_w[7];
        end
        S_FIN1: begin
          a_q <= IV[0]; b_q <= IV[1]; c_q <= IV[2]; d_q <= IV[3];
          e_q <= IV[4]; f_q <= IV[5]; g_q <= IV[6]; h_q <= IV[7];
        end
        S_RND1, S_RND2: begin
          h_q <= g_q;
          g_q <= f_q;
          f_q <= e_q;
          e_q <= d_q + t1;
          d_q <= c_q;
          c_q <= b_q;
          b_q <= a_q;
          a_q <= t1 + t2;
        end
        default: ;
      endcase
    end
  end

  // Message schedule. The window shifts down each round so w_q[0] is always
  // W[round]; equivalent to indexing a circular buffer by round mod 16.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      case (state)
        S_SETUP1: begin
          w_q[0] <= tail_q[95:64];
          w_q[1] <= tail_q[63:32];
          w_q[2] <= tail_q[31:0];
          w_q[3] <= 32'(nonce_q);
          w_q[4] <= 32'h80000000;
          for (int unsigned i = 5; i < 15; i++) w_q[i] <= '0;
          w_q[15] <= 32'd640;
        end
        S_FIN1: begin
          for (int unsigned i = 0; i < 8; i++) w_q[i] <= d1_w[i];
          w_q[8] <= 32'h80000000;
          for (int unsigned i = 9; i < 15; i++) w_q[i] <= '0;
          w_q[15] <= 32'd256;
        end
        S_RND1, S_RND2: begin
          for (int unsigned i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
          w_q[15] <= w_new;
        end
        default: ;
      endcase
    end
  end

  // Answer slots: each written only in its own nonce's final cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      answers <= '0;
    end else if (state == S_FIN2) begin
      answers[{nonce_q, 5'd0} +: 32] <= IV[0] + a_q;
    end
  end

endmodule

// File: tb/tb_nonce_hash_engine.sv
// Directed bench for nonce_hash_engine: golden sweep, single-nonce timing,
// ignored re-starts, mid-run reset, and back-to-back answer retention.
module tb_nonce_hash_engine;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [95:0] TAIL_X = {32'hdeadbeef, 32'h12345678, 32'hcafef00d};
  localparam logic [95:0] TAIL_Y = {32'h0badc0de, 32'h55aa55aa, 32'h00000001};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         start_a, busy_a, done_a;
  logic [255:0] mid_a;
  logic [95:0]  tail_a;
  logic [511:0] ans_a;
  logic         start_b, busy_b, done_b;
  logic [255:0] mid_b;
  logic [95:0]  tail_b;
  logic [31:0]  ans_b;

  nonce_hash_engine #(.NUM_NONCES(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .midstate(mid_a),
    .tail(tail_a), .busy(busy_a), .done(done_a), .answers(ans_a)
  );

  nonce_hash_engine #(.NUM_NONCES(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .midstate(mid_b),
    .tail(tail_b), .busy(busy_b), .done(done_b), .answers(ans_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [255:0] gold_mid;
  logic [31:0]  exp_x [16];
  logic [31:0]  exp_y [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression with a fully expanded 64-word schedule.
  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = v[i] + hin[255 - 32*i -: 32];
    return r;
  endfunction

  function automatic logic [31:0] exp_answer(input logic [255:0] ms, input logic [95:0] tl, input int n);
    logic [255:0] d1, d2;
    d1 = sha_compress(ms, {tl, 32'(n), 32'h80000000, 320'd0, 32'd640});
    d2 = sha_compress(IV, {d1, 32'h80000000, 192'd0, 32'd256});
    return d2[255:224];
  endfunction

  task automatic check_answers(input string pfx, input bit use_y);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_ans%0d", pfx, i), ans_a[32*i +: 32], use_y ? exp_y[i] : exp_x[i]);
  endtask

  // Starts dut_a and follows it edge by edge (edge 0 samples start).
  task automatic run_a(input int rp1, input int rp2, input int abort_at, input bit probe,
                       input bit chain, output int done_edge, output int done_cnt);
    int seen;
    done_edge = -1;
    done_cnt  = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 131*16 + 12; k++) begin
      start_a = (k == rp1 || k == rp2);
      if (start_a) begin
        mid_a  = ~mid_a;
        tail_a = ~tail_a;
      end
      if (k == abort_at) begin
        check("abort_ans_before", 32'(ans_a != '0), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_ans_cleared", 32'(ans_a != '0), 32'd0);
        seen = 0;
        repeat (3) begin @(posedge clk); #1; seen += int'(done_a); end
        reset_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; seen += int'(done_a) + int'(busy_a); end
        check("abort_quiet", 32'(seen), 32'd0);
        return;
      end
      @(posedge clk); #1;
      if (probe) begin
        if (k == 130) check("b2b_ans0_hold", ans_a[31:0], exp_x[0]);
        if (k == 131) begin
          check("b2b_ans0_new", ans_a[31:0], exp_y[0]);
          check("b2b_ans1_hold", ans_a[63:32], exp_x[1]);
          check("b2b_ans15_hold", ans_a[511:480], exp_x[15]);
        end
        if (k == 261) check("b2b_ans1_hold261", ans_a[63:32], exp_x[1]);
        if (k == 262) check("b2b_ans1_new", ans_a[63:32], exp_y[1]);
      end
      if (done_a) begin
        done_cnt++;
        if (done_edge < 0) done_edge = k;
        if (chain) return;
      end
    end
  endtask

  initial begin
    logic [511:0] blk;
    logic [255:0] dig;
    logic [31:0]  exp_b;
    int de, dc, busy_bad;

    // Reference sanity against published digests ("abc" and the empty message).
    dig = sha_compress(IV, {32'h61626380, 448'd0, 32'h00000018});
    check("ref_abc_h0", dig[255:224], 32'hba7816bf);
    check("ref_abc_h7", dig[31:0], 32'hf20015ad);
    dig = sha_compress(IV, {32'h80000000, 480'd0});
    check("ref_empty_h0", dig[255:224], 32'he3b0c442);

    for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = 32'h6b6f6e61 + 32'(i) * 32'h01030507;
    gold_mid = sha_compress(IV, blk);
    for (int i = 0; i < 16; i++) begin
      exp_x[i] = exp_answer(gold_mid, TAIL_X, i);
      exp_y[i] = exp_answer(gold_mid, TAIL_Y, i);
    end
    exp_b = exp_answer(IV, 96'd0, 0);

    reset_n = 1'b0;
    start_a = 1'b0; mid_a = '1; tail_a = '1;
    start_b = 1'b0; mid_b = '1; tail_b = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ans", 32'(ans_a != '0), 32'd0);
    check("rst_ans_b", ans_b, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy_a), 32'd0);
    check("idle_done", 32'(done_a), 32'd0);
    check("idle_ans", 32'(ans_a != '0), 32'd0);

    // Golden 16-nonce sweep.
    mid_a = gold_mid; tail_a = TAIL_X;
    run_a(-1, -1, -1, 1'b0, 1'b0, de, dc);
    check("gold_done_edge", 32'(de), 32'd2097);
    check("gold_done_count", 32'(dc), 32'd1);
    check("gold_busy_after", 32'(busy_a), 32'd0);
    check_answers("gold", 1'b0);

    // Re-pulsed start with scrambled inputs during the run.
    mid_a = gold_mid; tail_a = TAIL_X;
    run_a(10, 1000, -1, 1'b0, 1'b0, de, dc);
    check("repulse_done_edge", 32'(de), 32'd2097);
    check("repulse_done_count", 32'(dc), 32'd1);
    check_answers("repulse", 1'b0);

    // Reset mid-run.
    mid_a = gold_mid; tail_a = TAIL_X;
    run_a(-1, -1, 700, 1'b0, 1'b0, de, dc);

    // Fresh run after the abort, chained straight into a second run.
    mid_a = gold_mid; tail_a = TAIL_X;
    run_a(-1, -1, -1, 1'b0, 1'b1, de, dc);
    check("fresh_done_edge", 32'(de), 32'd2097);
    check_answers("fresh", 1'b0);
    tail_a = TAIL_Y;
    run_a(-1, -1, -1, 1'b1, 1'b0, de, dc);
    check("b2b_done_edge", 32'(de), 32'd2097);
    check("b2b_done_count", 32'(dc), 32'd1);
    check_answers("b2b", 1'b1);

    // Single-nonce instance: exact busy window and done edge.
    mid_b = IV; tail_b = '0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    de = -1; dc = 0; busy_bad = 0;
    for (int k = 1; k <= 145; k++) begin
      @(posedge clk); #1;
      if (busy_b !== (k <= 131)) busy_bad++;
      if (done_b) begin
        dc++;
        if (de < 0) de = k;
      end
    end
    check("one_done_edge", 32'(de), 32'd132);
    check("one_done_count", 32'(dc), 32'd1);
    check("one_busy_window", 32'(busy_bad), 32'd0);
    check("one_ans", ans_b, exp_b);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
